// File: rtl/fifo_rd_unpack_if.sv
// fifo_rd_unpack_if: FIFO read-side and output-stream signals of the unpacker.
//   rdata/rempty/rinc     : FIFO head word, empty flag, pop strobe
//   m_data/m_valid/m_ready/m_last : narrow output beat stream
//   word_cnt              : running count of popped words
// master = unpacker view, slave = FIFO/consumer view.
interface fifo_rd_unpack_if #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned OSIZE = 8,
  parameter int unsigned CNT_W = 16
);
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [OSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    input  rdata, rempty, m_ready,
    output rinc, m_data, m_valid, m_last, word_cnt
  );

  modport slave (
    output rdata, rempty, m_ready,
    input  rinc, m_data, m_valid, m_last, word_cnt
  );
endinterface

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: pops DSIZE-bit words from the async FIFO read port and emits
// each as DSIZE/OSIZE narrow beats on a valid/ready stream, counting pops.
//   rclk   : read-domain clock
//   rrst_n : synchronous active-low reset
//   bus    : FIFO read port (rdata/rempty/rinc), beat stream
//            (m_data/m_valid/m_ready/m_last) and popped-word count (word_cnt)
// rinc is combinational (m_ready -> rinc) so the next word reloads in the same
// cycle the last lane is accepted, giving one beat per cycle with no bubble.
module fifo_rd_unpack #(
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned OSIZE     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  fifo_rd_unpack_if.master bus
);

  localparam int unsigned RATIO  = DSIZE / OSIZE;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DSIZE-1:0]    r_word;
  logic [LANE_W-1:0]   r_lane;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_rinc;
  logic                w_last;
  logic                w_accept;
  logic [LANE_W-1:0]   w_sel;
  logic [DSIZE-1:0]    w_shifted;

  assign w_last   = (r_state == ST_HOLD) && (r_lane == LANE_W'(RATIO - 1));
  assign w_accept = (r_state == ST_HOLD) && bus.m_ready;

  // State register
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and pop strobe; a pop is only possible when the word register
  // is free or is being freed by acceptance of its last lane.
  always_comb begin
    w_next_state = r_state;
    w_rinc       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_rinc = rrst_n & ~bus.rempty;
        if (w_rinc) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.m_ready && w_last) begin
          w_rinc       = rrst_n & ~bus.rempty;
          w_next_state = w_rinc ? ST_HOLD : ST_EMPTY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // Word register, lane index and pop counter
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_word <= '0;
      r_lane <= '0;
      r_cnt  <= '0;
    end else if (w_rinc) begin
      r_word <= bus.rdata;
      r_lane <= '0;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else if (w_accept && !w_last) begin
      r_lane <= r_lane + LANE_W'(1);
    end
  end

  // Lane select: lane 0 maps to the low slice (LSB first) or the high slice.
  assign w_sel     = LSB_FIRST ? r_lane : (LANE_W'(RATIO - 1) - r_lane);
  assign w_shifted = r_word >> (32'(w_sel) * OSIZE);

  assign bus.rinc     = w_rinc;
  assign bus.m_valid  = (r_state == ST_HOLD);
  assign bus.m_last   = w_last;
  assign bus.m_data   = w_shifted[OSIZE-1:0];
  assign bus.word_cnt = r_cnt;

endmodule
